// File: rtl/tpu_arith_pkg.sv
// Shared definitions for the TPU datapath adders: op encoding and the
// chunk-width helpers used to split an operand across pipeline stages.
package tpu_arith_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic bit chunk_width_ok(int unsigned width, int unsigned num_stages);
        if (num_stages == 0 || width == 0) begin
            return 1'b0;
        end
        return (width % num_stages) == 0;
    endfunction

    // Falls back to 1 on an illegal split so the elaboration check is what reports it.
    function automatic int unsigned chunk_width(int unsigned width, int unsigned num_stages);
        if (!chunk_width_ok(width, num_stages)) begin
            return 1;
        end
        return width / num_stages;
    endfunction

endpackage

// File: rtl/cla_chunk.sv
// Combinational carry-lookahead adder over one CHUNK-bit slice, with group
// propagate/generate for a future second lookahead level.
module cla_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             grp_p,
    output logic             grp_g
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;

    assign g     = a & b;
    assign p     = a | b;
    assign grp_p = &p;

    always_comb begin
        logic c;
        logic gg;
        c  = ci;
        gg = 1'b0;
        s  = '0;
        for (int j = 0; j < CHUNK; j++) begin
            s[j] = a[j] ^ b[j] ^ c;
            c    = g[j] | (p[j] & c);
            gg   = g[j] | (p[j] & gg);
        end
        co    = c;
        grp_g = gg;
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one CHUNK-bit slice resolved per stage,
// carry registered between stages, valid/ready handshake with a single global advance.
module pipelined_cla_adder
    import tpu_arith_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUM_STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             out_ovf
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, NUM_STAGES);

    if (!chunk_width_ok(WIDTH, NUM_STAGES)) begin : g_param_check
        $error("pipelined_cla_adder: WIDTH %0d is not a multiple of NUM_STAGES %0d",
               WIDTH, NUM_STAGES);
    end

    // Stage k registers: operands still to be consumed, partial sum, carry out of chunk k.
    logic [NUM_STAGES-1:0]            valid_q;
    logic [NUM_STAGES-1:0]            carry_q;
    logic [NUM_STAGES-1:0][WIDTH-1:0] a_q;
    logic [NUM_STAGES-1:0][WIDTH-1:0] b_q;
    logic [NUM_STAGES-1:0][WIDTH-1:0] sum_q;
    logic                             ovf_q;

    // Combinational inputs/results of each stage, captured into the stage registers.
    logic [NUM_STAGES-1:0]            st_valid;
    logic [NUM_STAGES-1:0]            st_ci;
    logic [NUM_STAGES-1:0]            st_co;
    logic [NUM_STAGES-1:0]            st_grp_p;
    logic [NUM_STAGES-1:0]            st_grp_g;
    logic [NUM_STAGES-1:0][WIDTH-1:0] st_a;
    logic [NUM_STAGES-1:0][WIDTH-1:0] st_b;
    logic [NUM_STAGES-1:0][WIDTH-1:0] st_sum;

    logic [WIDTH-1:0] b_eff;
    logic             ci_eff;
    logic             en;
    logic             ovf_d;

    assign b_eff  = (in_sub == OP_ADD) ? in_b : ~in_b;
    assign ci_eff = (in_sub == OP_SUB) ? 1'b1 : in_ci;

    assign en       = out_ready | ~valid_q[NUM_STAGES-1];
    assign in_ready = en;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] s_chunk;

        if (k == 0) begin : g_head
            assign st_valid[k] = in_valid;
            assign st_a[k]     = in_a;
            assign st_b[k]     = b_eff;
            assign st_ci[k]    = ci_eff;
            assign st_sum[k]   = WIDTH'(s_chunk);
        end else begin : g_body
            assign st_valid[k] = valid_q[k-1];
            assign st_a[k]     = a_q[k-1];
            assign st_b[k]     = b_q[k-1];
            assign st_ci[k]    = carry_q[k-1];
            // Chunk k of the partial sum is still zero, so OR merges in the new slice.
            assign st_sum[k]   = sum_q[k-1] | (WIDTH'(s_chunk) << (k * CHUNK));
        end

        cla_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a     (st_a[k][k*CHUNK +: CHUNK]),
            .b     (st_b[k][k*CHUNK +: CHUNK]),
            .ci    (st_ci[k]),
            .s     (s_chunk),
            .co    (st_co[k]),
            .grp_p (st_grp_p[k]),
            .grp_g (st_grp_g[k])
        );
    end

    // Overflow is decided where the MSB chunk resolves, then registered with the sum.
    assign ovf_d = (st_a[NUM_STAGES-1][WIDTH-1] == st_b[NUM_STAGES-1][WIDTH-1]) &&
                   (st_sum[NUM_STAGES-1][WIDTH-1] != st_a[NUM_STAGES-1][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (en) begin
            valid_q <= st_valid;
            carry_q <= st_co;
            a_q     <= st_a;
            b_q     <= st_b;
            sum_q   <= st_sum;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = valid_q[NUM_STAGES-1];
    assign out_sum   = sum_q[NUM_STAGES-1];
    assign out_co    = carry_q[NUM_STAGES-1];
    assign out_ovf   = ovf_q;

    // Last-stage operands and group P/G have no consumer yet.
    logic unused_tail;
    assign unused_tail = ^{a_q[NUM_STAGES-1], b_q[NUM_STAGES-1], st_grp_p, st_grp_g};

endmodule
